// File: rtl/zx_intrst_ctrl.sv
// Interrupt/reset controller for NCH ZX-bus peripherals: pending/enable/mode registers,
// per-peripheral reset lines and the ZX /INT driver. Define EXT_INT_STRETCH_EN for fixed-width /INT pulses.
module zx_intrst_ctrl #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int INT_PULSE   = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [1:0]     i_reg_addr,
    input  logic           i_reg_wr,
    input  logic [7:0]     i_reg_wdata,
    output logic [7:0]     o_reg_rdata,
    input  logic [NCH-1:0] i_irq_in,
    output logic [NCH-1:0] o_per_rst_n,
    output logic           o_int_req,
    output logic           o_int_n
);

    logic [NCH-1:0] r_sync [SYNC_STAGES];
    logic [NCH-1:0] r_irq_prev;
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_ena;
    logic [NCH-1:0] r_mode;
    logic [NCH-1:0] r_per_rst_n;
    logic           r_eintena;
    logic           r_int_n;

    logic [NCH-1:0] w_irq_s;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_w1c;
    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_pend_next;
    logic           w_int_req;
    logic [7:0]     w_rdata;

    assign w_irq_s = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_irq_s & ~r_irq_prev;
    assign w_w1c   = (i_reg_wr && i_reg_addr == 2'd0) ? i_reg_wdata[NCH-1:0] : '0;

    // Edge-mode bits hold a latched edge; level-mode bits mirror the synchronised input.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_pend
            assign w_pend_next[gi] = r_mode[gi] ? (w_rise[gi] | (r_pend[gi] & ~w_w1c[gi])) : 1'b0;
            assign w_pend[gi]      = r_mode[gi] ? r_pend[gi] : w_irq_s[gi];
        end
    endgenerate

    assign w_int_req = |(w_pend & r_ena);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_irq_prev <= '0;
            r_pend     <= '0;
        end else begin
            r_sync[0] <= i_irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_irq_prev <= w_irq_s;
            r_pend     <= w_pend_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ena       <= '0;
            r_mode      <= '0;
            r_per_rst_n <= '0;
            r_eintena   <= 1'b0;
        end else if (i_reg_wr) begin
            case (i_reg_addr)
                2'd1: r_ena <= i_reg_wdata[NCH-1:0];
                2'd2: r_per_rst_n <= i_reg_wdata[NCH-1:0];
                2'd3: begin
                    r_mode    <= i_reg_wdata[NCH-1:0];
                    r_eintena <= i_reg_wdata[6];
                end
                default: ;
            endcase
        end
    end

`ifdef EXT_INT_STRETCH_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_WAIT_LOW} state_t;
    state_t     r_state;
    logic [7:0] r_cnt;

    // A request that stays active after its pulse must drop before the next pulse can start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_int_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_int_n <= 1'b1;
                    if (r_eintena && w_int_req) begin
                        r_state <= ST_ASSERT;
                        r_cnt   <= 8'(INT_PULSE - 1);
                        r_int_n <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (!r_eintena) begin
                        r_state <= ST_IDLE;
                        r_int_n <= 1'b1;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= ST_WAIT_LOW;
                        r_int_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_WAIT_LOW: begin
                    r_int_n <= 1'b1;
                    if (!w_int_req) r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_int_n <= 1'b1;
                end
            endcase
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_int_n <= 1'b1;
        else       r_int_n <= ~(r_eintena & w_int_req);
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (i_reg_addr)
            2'd0: w_rdata = 8'(w_pend);
            2'd1: w_rdata = 8'(r_ena);
            2'd2: w_rdata = 8'(r_per_rst_n);
            2'd3: w_rdata = {w_int_req, r_eintena, 6'(r_mode)};
            default: w_rdata = '0;
        endcase
    end

    assign o_reg_rdata = w_rdata;
    assign o_per_rst_n = r_per_rst_n;
    assign o_int_req   = w_int_req;
    assign o_int_n     = r_int_n;

endmodule

// File: tb/tb_zx_intrst_ctrl.sv
// Directed bench for zx_intrst_ctrl (NCH=4, SYNC_STAGES=2, INT_PULSE=32); inputs change 1ns after posedge.
module tb_zx_intrst_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] reg_addr = 2'd0;
    logic       reg_wr = 1'b0;
    logic [7:0] reg_wdata = 8'd0;
    logic [7:0] reg_rdata;
    logic [3:0] irq_in = 4'd0;
    logic [3:0] per_rst_n;
    logic       int_req;
    logic       int_n;

    int n_tests = 0;
    int n_fail  = 0;

    zx_intrst_ctrl #(.NCH(4), .SYNC_STAGES(2), .INT_PULSE(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_reg_addr(reg_addr), .i_reg_wr(reg_wr),
        .i_reg_wdata(reg_wdata), .o_reg_rdata(reg_rdata), .i_irq_in(irq_in),
        .o_per_rst_n(per_rst_n), .o_int_req(int_req), .o_int_n(int_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
            $display("[TB] %s ok: observed=%0h", tag, obs);
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
        reg_addr = a;
        #1;
        chk(tag, reg_rdata, exp);
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rd("rst_reg0", 2'd0, 8'h00);
        rd("rst_reg1", 2'd1, 8'h00);
        rd("rst_reg2", 2'd2, 8'h00);
        rd("rst_reg3", 2'd3, 8'h00);
        chk("rst_per_rst_n", 8'(per_rst_n), 8'h00);
        chk("rst_int_n", 8'(int_n), 8'h01);
        chk("rst_int_req", 8'(int_req), 8'h00);

        // Peripheral resets
        wr(2'd2, 8'h05);
        chk("per_rst_n_05", 8'(per_rst_n), 8'h05);
        rd("reg2_05", 2'd2, 8'h05);
        wr(2'd2, 8'hFF);
        rd("reg2_unused_bits", 2'd2, 8'h0F);

        // Level mode on channel 1
        wr(2'd1, 8'h02);
        wr(2'd3, 8'h40);
        irq_in = 4'b0010;
        tick();
        rd("lvl_reg0_edge1", 2'd0, 8'h00);
        tick();
        rd("lvl_reg0_edge2", 2'd0, 8'h02);
        chk("lvl_int_req", 8'(int_req), 8'h01);
        chk("lvl_int_n_edge2", 8'(int_n), 8'h01);
        rd("lvl_reg3", 2'd3, 8'hC0);
`ifndef EXT_INT_STRETCH_EN
        tick();
        chk("lvl_int_n_edge3", 8'(int_n), 8'h00);
        wr(2'd0, 8'h02);
        rd("lvl_w1c_ignored", 2'd0, 8'h02);
        irq_in = 4'b0000;
        tick();
        tick();
        chk("lvl_int_n_hold", 8'(int_n), 8'h00);
        tick();
        chk("lvl_int_n_release", 8'(int_n), 8'h01);
        rd("lvl_reg0_clear", 2'd0, 8'h00);
`else
        irq_in = 4'b0000;
        repeat (40) tick();
`endif

        // Edge mode on channel 0
        wr(2'd3, 8'h41);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        rd("edge_not_yet", 2'd0, 8'h00);
        tick();
        rd("edge_set", 2'd0, 8'h01);
        repeat (3) tick();
        rd("edge_persist", 2'd0, 8'h01);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        wr(2'd0, 8'h01);
        rd("edge_set_wins", 2'd0, 8'h01);
        wr(2'd0, 8'h01);
        rd("edge_w1c_clear", 2'd0, 8'h00);

        // Mode 1->0 discards latched edge; 0->1 with input high makes no spurious set
        irq_in = 4'b0001;
        repeat (3) tick();
        rd("edge_latched", 2'd0, 8'h01);
        irq_in = 4'b0000;
        repeat (2) tick();
        wr(2'd3, 8'h40);
        rd("mode_to_level", 2'd0, 8'h00);
        irq_in = 4'b0001;
        repeat (3) tick();
        rd("level_high", 2'd0, 8'h01);
        wr(2'd3, 8'h41);
        repeat (3) tick();
        rd("no_spurious", 2'd0, 8'h00);
        irq_in = 4'b0000;
        repeat (3) tick();

`ifdef EXT_INT_STRETCH_EN
        // Stretched /INT pulse
        begin
            int lo;
            int wt;
            for (int p = 0; p < 2; p++) begin
                irq_in = 4'b0010;
                wt = 0;
                while (int_n !== 1'b0 && wt < 20) begin tick(); wt++; end
                chk("stretch_start", 8'(int_n), 8'h00);
                lo = 0;
                while (int_n === 1'b0 && lo < 100) begin tick(); lo++; end
                chk("stretch_width", 8'(lo), 8'd32);
                repeat (10) tick();
                chk("stretch_no_second", 8'(int_n), 8'h01);
                irq_in = 4'b0000;
                repeat (5) tick();
            end
        end
`endif

        // Async reset mid-activity
        irq_in = 4'b0010;
        repeat (5) tick();
        chk("pre_rst_int_n", 8'(int_n), 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("async_int_n", 8'(int_n), 8'h01);
        chk("async_per_rst_n", 8'(per_rst_n), 8'h00);
        rd("async_reg1", 2'd1, 8'h00);
        rd("async_reg3", 2'd3, 8'h00);
        rd("async_reg0", 2'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
